// File: rtl/scroll_marquee_if.sv
// Marquee bus: scroll controls and message in, segment window and step pulses out.
//   en   : prescaler/scroll enable
//   dir  : 0 = text moves left, 1 = text moves right
//   msg  : MSG_LEN active-low glyphs, msg[6:0] is the first character
//   hex  : DIGITS registered active-low glyphs, hex[7*i+:7] drives display i
//   step : one-cycle pulse with the first window after a scroll step
//   wrap : one-cycle pulse with step when the new position is 0
interface scroll_marquee_if #(
    parameter int unsigned DIGITS  = 8,
    parameter int unsigned MSG_LEN = 5
);
    logic                   en;
    logic                   dir;
    logic [7*MSG_LEN-1:0]   msg;
    logic [7*DIGITS-1:0]    hex;
    logic                   step;
    logic                   wrap;

    modport master (output en, dir, msg, input hex, step, wrap);
    modport slave  (input en, dir, msg, output hex, step, wrap);
endinterface

// File: rtl/scroll_marquee.sv
// Scrolling-text driver for a bank of active-low seven-segment displays.
// The message plus GAP blanks forms a circular tape; a DIGITS-wide window
// slides along it once every DIV enabled cycles.
//   clk : rising-edge clock
//   clr : synchronous active-high reset
//   bus : scroll_marquee_if slave (en, dir, msg in; hex, step, wrap out)
module scroll_marquee #(
    parameter int unsigned DIGITS  = 8,
    parameter int unsigned MSG_LEN = 5,
    parameter int unsigned GAP     = 3,
    parameter int unsigned DIV     = 25000000
) (
    input  logic              clk,
    input  logic              clr,
    scroll_marquee_if.slave   bus
);
    localparam int unsigned TAPE_LEN = MSG_LEN + GAP;
    localparam int unsigned POS_W    = (TAPE_LEN > 1) ? $clog2(TAPE_LEN) : 1;
    localparam int unsigned SUM_W    = POS_W + 1;
    localparam int unsigned CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0]       cnt;
    logic [POS_W-1:0]       pos;
    logic [POS_W-1:0]       pos_next_c;
    logic                   tick_c;
    logic                   tick_q;
    logic                   wrap_q;
    logic [7*TAPE_LEN-1:0]  tape_c;
    logic [7*DIGITS-1:0]    hex_next_c;

    // Prescaler terminal count
    always_comb begin
        tick_c = bus.en && (cnt == CNT_W'(DIV - 1));
    end

    // Circular position step in the selected direction
    always_comb begin
        pos_next_c = pos;
        if (bus.dir) begin
            pos_next_c = (pos == '0) ? POS_W'(TAPE_LEN - 1) : pos - POS_W'(1);
        end else begin
            pos_next_c = (pos == POS_W'(TAPE_LEN - 1)) ? '0 : pos + POS_W'(1);
        end
    end

    // Tape: message glyphs followed by blank (all segments off) positions
    always_comb begin
        tape_c                 = '1;
        tape_c[7*MSG_LEN-1:0]  = bus.msg;
    end

    // Per-display tape index: the constant offset is pre-reduced mod TAPE_LEN,
    // so pos + offset < 2*TAPE_LEN and a single conditional subtract suffices.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        localparam int unsigned OFF = (DIGITS - 1 - i) % TAPE_LEN;
        logic [SUM_W-1:0] sum_c;
        logic [SUM_W-1:0] idx_c;
        assign sum_c = SUM_W'(pos) + SUM_W'(OFF);
        assign idx_c = (sum_c >= SUM_W'(TAPE_LEN)) ? sum_c - SUM_W'(TAPE_LEN) : sum_c;
        assign hex_next_c[7*i +: 7] = tape_c[7*idx_c +: 7];
    end

    // State and output registers; step/wrap are delayed one cycle so they
    // line up with the first window drawn from the new position.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt      <= '0;
            pos      <= '0;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
            bus.hex  <= '1;
            bus.step <= 1'b0;
            bus.wrap <= 1'b0;
        end else begin
            if (bus.en) begin
                cnt <= tick_c ? '0 : cnt + CNT_W'(1);
            end
            if (tick_c) begin
                pos <= pos_next_c;
            end
            tick_q   <= tick_c;
            wrap_q   <= tick_c && (pos_next_c == '0);
            bus.hex  <= hex_next_c;
            bus.step <= tick_q;
            bus.wrap <= wrap_q;
        end
    end
endmodule

// File: tb/tb_scroll_marquee.sv
// Bench for scroll_marquee: table of scripted segments with fixed expected
// windows, a per-cycle scoreboard fed by a reference model, then a random run.
module tb_scroll_marquee;
    localparam int unsigned DIGITS   = 8;
    localparam int unsigned MSG_LEN  = 5;
    localparam int unsigned GAP      = 3;
    localparam int unsigned DIV      = 4;
    localparam int unsigned TAPE_LEN = MSG_LEN + GAP;

    localparam logic [6:0] GZ = 7'b0100100;
    localparam logic [6:0] GO = 7'b0100011;
    localparam logic [6:0] GH = 7'b0001011;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GN = 7'b0101011;
    localparam logic [6:0] GB = 7'b1111111;

    localparam logic [34:0] MSG0   = {GN, GA, GH, GO, GZ};
    localparam logic [34:0] MSG_BZ = {GN, GA, GH, GO, GB};

    localparam logic [55:0] BLANK = {56{1'b1}};
    localparam logic [55:0] W0  = {GZ, GO, GH, GA, GN, GB, GB, GB};
    localparam logic [55:0] W1  = {GO, GH, GA, GN, GB, GB, GB, GZ};
    localparam logic [55:0] W2  = {GH, GA, GN, GB, GB, GB, GZ, GO};
    localparam logic [55:0] W3  = {GA, GN, GB, GB, GB, GZ, GO, GH};
    localparam logic [55:0] W7  = {GB, GZ, GO, GH, GA, GN, GB, GB};
    localparam logic [55:0] W1X = {GO, GH, GA, GN, GB, GB, GB, GB};

    typedef struct {
        logic        clr;
        logic        en;
        logic        dir;
        logic [34:0] msg;
        int          cycles;
        logic [55:0] hex;
        logic        step;
        logic        wrap;
    } vec_t;

    typedef struct {
        logic [55:0] hex;
        logic        step;
        logic        wrap;
    } exp_t;

    logic clk = 1'b0;
    logic clr;

    scroll_marquee_if #(.DIGITS(DIGITS), .MSG_LEN(MSG_LEN)) bus ();

    scroll_marquee #(
        .DIGITS (DIGITS),
        .MSG_LEN(MSG_LEN),
        .GAP    (GAP),
        .DIV    (DIV)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_bad = 0;
    int   m_cnt = 0;
    int   m_pos = 0;
    logic m_step_p = 1'b0;
    logic m_wrap_p = 1'b0;
    exp_t sb[$];
    vec_t vt[$];

    function automatic logic [55:0] window(input int p, input logic [34:0] m);
        logic [55:0] w;
        int idx;
        w = '1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            idx = (p + int'(DIGITS) - 1 - i) % int'(TAPE_LEN);
            w[7*i +: 7] = (idx < int'(MSG_LEN)) ? m[7*idx +: 7] : GB;
        end
        return w;
    endfunction

    // One clock: drive inputs, queue the predicted output, check after the edge
    task automatic cycle(input logic c, input logic e, input logic d, input logic [34:0] m);
        exp_t x;
        exp_t got;
        logic tick;
        @(negedge clk);
        clr     = c;
        bus.en  = e;
        bus.dir = d;
        bus.msg = m;
        if (c) begin
            x.hex  = '1;
            x.step = 1'b0;
            x.wrap = 1'b0;
        end else begin
            x.hex  = window(m_pos, m);
            x.step = m_step_p;
            x.wrap = m_wrap_p;
        end
        sb.push_back(x);
        if (c) begin
            m_cnt = 0; m_pos = 0; m_step_p = 1'b0; m_wrap_p = 1'b0;
        end else begin
            tick = e && (m_cnt == int'(DIV) - 1);
            if (e) m_cnt = tick ? 0 : m_cnt + 1;
            if (tick) m_pos = d ? (m_pos + int'(TAPE_LEN) - 1) % int'(TAPE_LEN)
                                : (m_pos + 1) % int'(TAPE_LEN);
            m_step_p = tick;
            m_wrap_p = tick && (m_pos == 0);
        end
        @(posedge clk);
        #1;
        got.hex  = bus.hex;
        got.step = bus.step;
        got.wrap = bus.wrap;
        x = sb.pop_front();
        n_vec++;
        if (got.hex !== x.hex || got.step !== x.step || got.wrap !== x.wrap) begin
            n_bad++;
            $display("FAIL scoreboard t=%0t: got hex=%h step=%b wrap=%b, want hex=%h step=%b wrap=%b",
                     $time, got.hex, got.step, got.wrap, x.hex, x.step, x.wrap);
        end
    endtask

    task automatic add(input logic c, input logic e, input logic d, input logic [34:0] m,
                       input int n, input logic [55:0] h, input logic s, input logic w);
        vec_t v;
        v.clr = c; v.en = e; v.dir = d; v.msg = m; v.cycles = n;
        v.hex = h; v.step = s; v.wrap = w;
        vt.push_back(v);
    endtask

    initial begin
        clr     = 1'b1;
        bus.en  = 1'b0;
        bus.dir = 1'b0;
        bus.msg = MSG0;

        // Reset, then left scroll through a full wrap
        add(1, 1, 0, MSG0,    3, BLANK, 0, 0);
        add(0, 1, 0, MSG0,    1, W0,    0, 0);
        add(0, 1, 0, MSG0,    4, W1,    1, 0);
        add(0, 1, 0, MSG0,    1, W1,    0, 0);
        add(0, 1, 0, MSG0,   27, W0,    1, 1);
        // Right scroll from reset
        add(1, 1, 1, MSG0,    1, BLANK, 0, 0);
        add(0, 1, 1, MSG0,    5, W7,    1, 0);
        add(0, 1, 1, MSG0,   28, W0,    1, 1);
        // Freeze at cnt=2, resume: tick after 2 enabled cycles
        add(0, 1, 1, MSG0,    1, W0,    0, 0);
        add(0, 0, 1, MSG0,   10, W0,    0, 0);
        add(0, 1, 1, MSG0,    1, W0,    0, 0);
        add(0, 1, 1, MSG0,    1, W0,    0, 0);
        add(0, 1, 1, MSG0,    1, W7,    1, 0);
        // Direction change mid-count, run to pos=3 cnt=3, reset on tick edge
        add(0, 1, 0, MSG0,   16, W3,    1, 0);
        add(0, 1, 0, MSG0,    2, W3,    0, 0);
        add(1, 1, 0, MSG0,    1, BLANK, 0, 0);
        add(0, 1, 0, MSG0,    1, W0,    0, 0);
        add(0, 1, 0, MSG0,    3, W0,    0, 0);
        add(0, 1, 0, MSG0,    1, W1,    1, 0);
        // Live message change while frozen; pos and cnt unchanged afterwards
        add(0, 0, 0, MSG_BZ,  1, W1X,   0, 0);
        add(0, 0, 0, MSG_BZ,  3, W1X,   0, 0);
        add(0, 1, 0, MSG0,    2, W1,    0, 0);
        add(0, 1, 0, MSG0,    1, W1,    0, 0);
        add(0, 1, 0, MSG0,    1, W2,    1, 0);

        for (int r = 0; r < vt.size(); r++) begin
            for (int k = 0; k < vt[r].cycles; k++) begin
                cycle(vt[r].clr, vt[r].en, vt[r].dir, vt[r].msg);
            end
            n_vec++;
            if (bus.hex !== vt[r].hex || bus.step !== vt[r].step || bus.wrap !== vt[r].wrap) begin
                n_bad++;
                $display("FAIL row %0d: got hex=%h step=%b wrap=%b, want hex=%h step=%b wrap=%b",
                         r, bus.hex, bus.step, bus.wrap, vt[r].hex, vt[r].step, vt[r].wrap);
            end
        end

        // Random run against the reference model
        begin
            logic [34:0] m;
            m = MSG0;
            for (int k = 0; k < 400; k++) begin
                if ($urandom_range(0, 19) == 0) m = 35'($urandom) ^ {3'b0, 32'($urandom)} << 3;
                cycle(logic'($urandom_range(0, 39) == 0),
                      logic'($urandom_range(0, 3) != 0),
                      logic'(k >= 200),
                      m);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
